// File: rtl/instr_fetch_112_pkg.sv
// Shared definitions for the instruction fetch stage and its decoder neighbour.
// Holds the fetch FSM state encoding, the opcode constants shared with the
// main control decoder, the PC step and the branch-offset helper.
package instr_fetch_112_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Word offset of a branch, sign-extended and converted to a byte offset.
  function automatic logic signed [31:0] br_offset(input logic [15:0] imm);
    return $signed({{14{imm[15]}}, imm, 2'b00});
  endfunction

endpackage

// File: rtl/instr_fetch_112_npc.sv
// Next-PC computation for the fetch stage (purely combinational).
// Ports:
//   pc     in  32  address of the current instruction
//   instr  in  32  current instruction word
//   branch in  1   decoder Branch output
//   zero   in  1   ALU zero flag
//   jump   in  1   decoder Jump output (wins over branch)
//   npc    out 32  address of the next instruction, always word aligned
module npc_112
  import instr_fetch_112_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] npc
);

  logic [31:0]        pc4;
  logic signed [31:0] boff;
  logic [31:0]        br_target;
  logic [31:0]        j_target;
  logic               unused_opcode;

  assign pc4       = pc + PC_STEP;
  assign boff      = br_offset(instr[15:0]);
  assign br_target = pc4 + $unsigned(boff);
  // Jump keeps the 256 MB region of the sequential address.
  assign j_target  = {pc4[31:28], instr[25:0], 2'b00};
  // The opcode field is the decoder's business, not ours.
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    npc = pc4;
    if (jump) begin
      npc = j_target;
    end else if (branch && zero) begin
      npc = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch_112.sv
// Instruction fetch stage feeding the main control decoder.
// Owns the PC, fetches one word per instruction over a req/ack handshake,
// holds it in the instruction register until the datapath retires it, then
// advances the PC using the decoder's Branch/Jump and the ALU zero flag.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/addr       fetch request and byte address (addr mirrors pc)
//   imem_ack/rdata      memory response, sampled only while fetching
//   instr, instr_valid  instruction register and its "fresh, not retired" flag
//   pc                  address of the word in instr
//   retire              datapath finished the held instruction
//   branch, zero, jump  next-PC controls, sampled only while holding
//   retired_cnt         wrapping count of retired instructions
module instr_fetch_112
  import instr_fetch_112_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [31:0]          pc,
  input  logic                 retire,
  input  logic                 branch,
  input  logic                 zero,
  input  logic                 jump,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  state_t      state, state_nxt;
  logic [31:0] npc;
  logic        load_ir;
  logic        advance;

  npc_112 u_npc (
    .pc     (pc),
    .instr  (instr),
    .branch (branch),
    .zero   (zero),
    .jump   (jump),
    .npc    (npc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_ir     = 1'b0;
    advance     = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_ir   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (retire) begin
          advance   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // pc and instr only move on their own events, so while fetching the
  // decoder keeps seeing the last retired word (flagged stale).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      retired_cnt <= '0;
    end else begin
      if (load_ir) begin
        instr <= imem_rdata;
      end
      if (advance) begin
        pc          <= npc;
        retired_cnt <= retired_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_instr_fetch_112.sv
// Testbench for instr_fetch_112: directed scenarios plus a randomized
// instruction stream, checked against a simple next-PC/count model.
module tb_instr_fetch_112;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        retire = 1'b0, branch = 1'b0, zero = 1'b0, jump = 1'b0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc;
  logic [31:0] retired_cnt;

  logic        ack_b = 1'b0, retire_b = 1'b0, br_b = 1'b0, z_b = 1'b0, j_b = 1'b0;
  logic [31:0] rdata_b = 32'h0;
  logic        req_b, valid_b;
  logic [31:0] addr_b, instr_b, pc_b;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc, exp_instr, exp_cnt;

  always #5 clk = ~clk;

  instr_fetch_112 dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .retire(retire), .branch(branch),
    .zero(zero), .jump(jump), .retired_cnt(retired_cnt)
  );

  instr_fetch_112 #(.RESET_PC(32'hFFFF_FFFC), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(ack_b), .imem_rdata(rdata_b), .instr(instr_b),
    .instr_valid(valid_b), .pc(pc_b), .retire(retire_b), .branch(br_b),
    .zero(z_b), .jump(j_b), .retired_cnt(cnt_b)
  );

  // Reference next-PC, written from the architectural rule.
  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] w,
                                            input bit b, input bit z, input bit j);
    logic [31:0] seq;
    logic [15:0] imm;
    int off;
    seq = p + 32'd4;
    imm = w[15:0];
    off = int'($signed(imm)) * 4;
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && z) return seq + 32'(off);
    return seq;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetching(input string tag);
    check({tag, " req"}, {31'h0, imem_req}, 32'h1);
    check({tag, " addr"}, imem_addr, exp_pc);
    check({tag, " valid"}, {31'h0, instr_valid}, 32'h0);
    check({tag, " instr"}, instr, exp_instr);
    check({tag, " cnt"}, retired_cnt, exp_cnt);
  endtask

  // Called at posedge+1 with reset already asserted.
  task automatic release_reset();
    exp_pc = RPC; exp_instr = 32'h0; exp_cnt = 32'h0;
    imem_ack = 1'b0; retire = 1'b0;
    rst_n = 1'b1;
    #1;
    check("idle req", {31'h0, imem_req}, 32'h0);
    check("idle pc", pc, RPC);
    tick();
    check_fetching("first fetch");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst req", {31'h0, imem_req}, 32'h0);
    check("rst valid", {31'h0, instr_valid}, 32'h0);
    check("rst pc", pc, RPC);
    check("rst instr", instr, 32'h0);
    check("rst cnt", retired_cnt, 32'h0);
    tick();
    tick();
    release_reset();
  endtask

  // In S_FETCH: wait `dly` cycles (with stray retire pulses), then ack `w`.
  task automatic fetch(input logic [31:0] w, input int dly);
    for (int i = 0; i < dly; i++) begin
      retire = 1'($urandom); branch = 1'($urandom);
      zero = 1'($urandom); jump = 1'($urandom);
      imem_rdata = $urandom;
      tick();
      check_fetching("fetch wait");
    end
    retire = 1'b0;
    imem_ack = 1'b1; imem_rdata = w;
    tick();
    imem_ack = 1'b0;
    exp_instr = w;
    check("hold valid", {31'h0, instr_valid}, 32'h1);
    check("hold req", {31'h0, imem_req}, 32'h0);
    check("hold instr", instr, w);
    check("hold pc", pc, exp_pc);
  endtask

  // In S_HOLD: wait `dly` cycles (with stray acks), then retire.
  task automatic do_retire(input bit b, input bit z, input bit j, input int dly);
    for (int i = 0; i < dly; i++) begin
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      tick();
      check("hold wait valid", {31'h0, instr_valid}, 32'h1);
      check("hold wait instr", instr, exp_instr);
      check("hold wait pc", pc, exp_pc);
    end
    imem_ack = 1'b0;
    retire = 1'b1; branch = b; zero = z; jump = j;
    tick();
    retire = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    exp_pc = model_npc(exp_pc, exp_instr, b, z, j);
    exp_cnt = exp_cnt + 1;
    check_fetching("after retire");
  endtask

  initial begin
    tick();
    tick();
    // Reset then sequential fetch.
    release_reset();
    fetch(32'h3408_0005, 0);
    do_retire(1'b0, 1'b0, 1'b0, 0);
    check("seq pc", pc, 32'h0000_3004);
    check("seq cnt", retired_cnt, 32'd1);

    // Taken branch forward, backward, and not-taken.
    do_reset();
    fetch(32'h1000_0003, 0);
    do_retire(1'b1, 1'b1, 1'b0, 0);
    check("beq fwd", pc, 32'h0000_3010);
    do_reset();
    fetch(32'h1000_FFFF, 0);
    do_retire(1'b1, 1'b1, 1'b0, 0);
    check("beq back", pc, 32'h0000_3000);
    do_reset();
    fetch(32'h1000_0003, 0);
    do_retire(1'b1, 1'b0, 1'b0, 0);
    check("beq nt", pc, 32'h0000_3004);

    // Jump beats branch.
    do_reset();
    fetch(32'h0800_0C10, 0);
    do_retire(1'b1, 1'b1, 1'b1, 0);
    check("jump", pc, 32'h0000_3040);

    // Slow memory with stray retire pulses, then stray acks while holding.
    fetch(32'h2000_1234, 5);
    do_retire(1'b0, 1'b0, 1'b0, 4);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      fetch($urandom, int'($urandom_range(0, 3)));
      do_retire(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of a fetch.
    #2;
    rst_n = 1'b0;
    #1;
    check("async req", {31'h0, imem_req}, 32'h0);
    check("async pc", pc, RPC);
    check("async cnt", retired_cnt, 32'h0);
    check("async valid", {31'h0, instr_valid}, 32'h0);
    tick();
    release_reset();
    fetch(32'h0000_0000, 1);
    do_retire(1'b0, 1'b0, 1'b0, 0);
    check("restart pc", pc, 32'h0000_3004);

    // PC and counter wrap on the narrow-counter instance.
    tick();
    check("wrap req", {31'h0, req_b}, 32'h1);
    check("wrap addr0", addr_b, 32'hFFFF_FFFC);
    for (int k = 1; k <= 16; k++) begin
      ack_b = 1'b1; rdata_b = 32'h0;
      tick();
      ack_b = 1'b0; retire_b = 1'b1;
      tick();
      retire_b = 1'b0;
      if (k == 1) begin
        check("wrap pc", pc_b, 32'h0000_0000);
        check("wrap cnt1", {28'h0, cnt_b}, 32'd1);
      end
    end
    check("cnt wrap", {28'h0, cnt_b}, 32'd0);
    check("wrap pc16", pc_b, 32'h0000_003C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
